// File: rtl/spi_ram_pkg.sv
// Shared constants, FSM state type and byte-order helper for the SPI RAM arbiter.
package spi_ram_pkg;

  localparam int FRAME_BITS     = 64;
  localparam int WIRE_ADDR_BITS = 24;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_e;

  // Data travels least-significant byte first, so the wire image is the byte-reversed word.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_ram_shifter.sv
// SPI mode-0 frame engine: one load cycle after start, then 64 bits at 2 clk per bit,
// then chip select released. Exposes the last 32 MISO bits including the final sample.
module spi_ram_shifter
  import spi_ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start_i,
  input  logic [FRAME_BITS-1:0] frame_i,
  output logic                  last_o,
  output logic [31:0]           rx_word_o,
  output logic                  sck_o,
  output logic                  cs_n_o,
  output logic                  mosi_o,
  input  logic                  miso_i
);

  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [31:0]           rx_q, rx_d, rx_next;
  logic [7:0]            cnt_q, cnt_d;
  logic                  run_q, run_d;
  logic                  sck_q, sck_d;
  logic                  cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;

  // cnt_q indexes half-bit slots: even = phase 0 (sck low), odd = phase 1 (sck high), 128 = release.
  always_comb begin
    frame_d = frame_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    rx_next = {rx_q[30:0], miso_i};

    if (start_i) begin
      frame_d = frame_i;
      cnt_d   = 8'd0;
      run_d   = 1'b1;
    end else if (run_q) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_q != 8'd0 && !cnt_q[0]) begin
        rx_d = rx_next;
      end
      if (cnt_q == 8'd128) begin
        run_d  = 1'b0;
        cs_n_d = 1'b1;
        sck_d  = 1'b0;
        mosi_d = 1'b0;
      end else begin
        cs_n_d = 1'b0;
        if (!cnt_q[0]) begin
          sck_d  = 1'b0;
          mosi_d = frame_q[FRAME_BITS-1];
        end else begin
          sck_d   = 1'b1;
          frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_q <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      frame_q <= frame_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
    end
  end

  assign last_o    = run_q && (cnt_q == 8'd128);
  assign rx_word_o = rx_next;
  assign sck_o     = sck_q;
  assign cs_n_o    = cs_n_q;
  assign mosi_o    = mosi_q;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Two-port arbiter in front of an SPI RAM; one 64-bit word frame per transaction.
// Define SPI_RAM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port A.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 a_valid,
  input  logic                 a_we,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [31:0]          a_wdata,
  output logic                 a_ready,
  output logic [31:0]          a_rdata,
  input  logic                 b_valid,
  input  logic                 b_we,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [31:0]          b_wdata,
  output logic                 b_ready,
  output logic [31:0]          b_rdata,
  output logic                 spi_clk_ram,
  output logic                 spi_cs_n_ram,
  output logic                 spi_mosi_ram,
  input  logic                 spi_miso_ram
);

  state_e                    state_q, state_d;
  port_e                     grant_q, grant_d, winner;
  logic                      we_q, we_d;
  logic [31:0]               a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                      sel_we;
  logic [WIRE_ADDR_BITS-1:0] sel_addr;
  logic [31:0]               sel_wdata;
  logic [FRAME_BITS-1:0]     frame;
  logic                      start, last;
  logic [31:0]               rx_word;

`ifdef SPI_RAM_ARB_RR_EN
  port_e last_grant_q, last_grant_d;

  always_comb begin
    if (a_valid && b_valid) begin
      winner = (last_grant_q == PORT_A) ? PORT_B : PORT_A;
    end else begin
      winner = a_valid ? PORT_A : PORT_B;
    end
    last_grant_d = start ? winner : last_grant_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= PORT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign winner = a_valid ? PORT_A : PORT_B;
`endif

  always_comb begin
    sel_we    = (winner == PORT_A) ? a_we : b_we;
    sel_addr  = (winner == PORT_A) ? WIRE_ADDR_BITS'(a_addr) : WIRE_ADDR_BITS'(b_addr);
    sel_wdata = (winner == PORT_A) ? a_wdata : b_wdata;
    frame     = {sel_we ? CMD_WRITE : CMD_READ, sel_addr,
                 sel_we ? byte_swap32(sel_wdata) : 32'h0};
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    we_d      = we_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    start     = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_valid || b_valid) begin
          start   = 1'b1;
          grant_d = winner;
          we_d    = sel_we;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          state_d = DONE;
          if (!we_q) begin
            if (grant_q == PORT_A) a_rdata_d = byte_swap32(rx_word);
            else                   b_rdata_d = byte_swap32(rx_word);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= PORT_A;
      we_q      <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      we_q      <= we_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_ready = (state_q == DONE) && (grant_q == PORT_A);
  assign b_ready = (state_q == DONE) && (grant_q == PORT_B);
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

  spi_ram_shifter u_shifter (
    .clk       (clk),
    .resetn    (resetn),
    .start_i   (start),
    .frame_i   (frame),
    .last_o    (last),
    .rx_word_o (rx_word),
    .sck_o     (spi_clk_ram),
    .cs_n_o    (spi_cs_n_ram),
    .mosi_o    (spi_mosi_ram),
    .miso_i    (spi_miso_ram)
  );

endmodule
